// File: rtl/video_sig_gen.sv
// Raster timing master (1024x768@60 by default): counters, sync/blank decodes, frame counter,
// and a return-path delay line that lines syncs and blanking up with the pixel pipeline output.
module video_sig_gen #(
  parameter int ACTIVE_H    = 1024,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 136,
  parameter int H_BP        = 160,
  parameter int ACTIVE_V    = 768,
  parameter int V_FP        = 3,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 29,
  parameter int FPS         = 60,
  parameter int PIPE_STAGES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] pixel_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out,
  output logic        hs_d_out,
  output logic        vs_d_out,
  output logic        ad_d_out,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048) begin : g_h_total_too_big
    $error("video_sig_gen: H_TOTAL does not fit an 11-bit hcount");
  end
  if (V_TOTAL > 1024) begin : g_v_total_too_big
    $error("video_sig_gen: V_TOTAL does not fit a 10-bit vcount");
  end
  if (FPS < 1 || FPS > 64) begin : g_fps_bad
    $error("video_sig_gen: FPS does not fit a 6-bit frame counter");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(ACTIVE_H);
  localparam logic [10:0] HS_FIRST = 11'(ACTIVE_H + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(ACTIVE_H + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(ACTIVE_V);
  localparam logic [9:0]  VS_FIRST = 10'(ACTIVE_V + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(ACTIVE_V + V_FP + V_SYNC - 1);
  localparam logic [5:0]  FC_LAST  = 6'(FPS - 1);

  logic        run_q;
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d, vs_q, vs_d, ad_q, ad_d, nf_q, nf_d;
  logic [5:0]  fc_q, fc_d;

  // Reset release synchronizer: counting begins the edge after this flop rises.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Next counter values; decodes use them so every decode matches the count it ships with.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (run_q) begin
      if (hcount_q == H_LAST) begin
        hcount_d = 11'd0;
        if (vcount_q == V_LAST) begin
          vcount_d = 10'd0;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
      end
    end else begin
      hcount_d = hcount_q;
      vcount_d = vcount_q;
    end
    ad_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
    hs_d = !((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST));
    vs_d = !((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST));
    nf_d = run_q && (hcount_d == H_ACT) && (vcount_d == V_ACT);
    if (nf_d) begin
      fc_d = (fc_q == FC_LAST) ? 6'd0 : fc_q + 6'd1;
    end else begin
      fc_d = fc_q;
    end
  end

  // Raster state and decode registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hcount_q <= 11'd0;
      vcount_q <= 10'd0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      ad_q     <= 1'b1;
      nf_q     <= 1'b0;
      fc_q     <= 6'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
      fc_q     <= fc_d;
    end
  end

  // Delay line: bit i holds the decode from i+1 cycles ago; ad_tap_s lines up with pixel_in.
  logic [PIPE_STAGES:0] hs_sr_q, vs_sr_q, ad_sr_q;
  logic [PIPE_STAGES:0] hs_shift_s, vs_shift_s, ad_shift_s;
  logic                 ad_tap_s;
  logic [11:0]          rgb_q;

  if (PIPE_STAGES == 0) begin : g_no_pipe
    assign hs_shift_s = hs_q;
    assign vs_shift_s = vs_q;
    assign ad_shift_s = ad_q;
    assign ad_tap_s   = ad_q;
  end else begin : g_pipe
    assign hs_shift_s = {hs_sr_q[PIPE_STAGES-1:0], hs_q};
    assign vs_shift_s = {vs_sr_q[PIPE_STAGES-1:0], vs_q};
    assign ad_shift_s = {ad_sr_q[PIPE_STAGES-1:0], ad_q};
    assign ad_tap_s   = ad_sr_q[PIPE_STAGES-1];
  end

  // Return path; the blanking mux keeps unknown pixels off rgb_out outside the active area.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hs_sr_q <= {(PIPE_STAGES+1){1'b1}};
      vs_sr_q <= {(PIPE_STAGES+1){1'b1}};
      ad_sr_q <= {(PIPE_STAGES+1){1'b0}};
      rgb_q   <= 12'h000;
    end else begin
      hs_sr_q <= hs_shift_s;
      vs_sr_q <= vs_shift_s;
      ad_sr_q <= ad_shift_s;
      rgb_q   <= ad_tap_s ? pixel_in : 12'h000;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;
  assign hs_d_out   = hs_sr_q[PIPE_STAGES];
  assign vs_d_out   = vs_sr_q[PIPE_STAGES];
  assign ad_d_out   = ad_sr_q[PIPE_STAGES];
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: full 1024x768 instance (4-stage pixel pipe) and a tiny 8x6 instance
// (no pixel pipe) checked every cycle against an arithmetic raster model, plus directed points.
module tb_video_sig_gen;

  typedef struct {
    int ah; int hfp; int hsw; int hbp;
    int av; int vfp; int vsw; int vbp;
    int fps; int pipe;
  } cfg_t;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
  } raster_t;

  typedef struct {
    int rst; int adv;
    int h; int v; int hs; int vs; int ad; int nf; int fc;
  } vec_t;

  logic clk;
  logic rst_a, rst_b;
  logic [11:0] pix_a, pix_b;
  logic [10:0] h_a, h_b;
  logic [9:0]  v_a, v_b;
  logic hs_a, vs_a, ad_a, nf_a, hsd_a, vsd_a, add_a;
  logic hs_b, vs_b, ad_b, nf_b, hsd_b, vsd_b, add_b;
  logic [5:0]  fc_a, fc_b;
  logic [11:0] rgb_a, rgb_b;

  int n_tests = 0;
  int n_fail  = 0;
  int k_a = 0, k_b = 0;
  logic [11:0] prev_a = 12'h000, prev_b = 12'h000;
  cfg_t cfg_a, cfg_b;
  vec_t vecs [11];

  video_sig_gen dut_a (
    .clk_in(clk), .rst_in(rst_a), .pixel_in(pix_a),
    .hcount_out(h_a), .vcount_out(v_a), .hs_out(hs_a), .vs_out(vs_a), .ad_out(ad_a),
    .nf_out(nf_a), .fc_out(fc_a), .hs_d_out(hsd_a), .vs_d_out(vsd_a), .ad_d_out(add_a),
    .rgb_out(rgb_a)
  );

  video_sig_gen #(
    .ACTIVE_H(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .ACTIVE_V(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FPS(60), .PIPE_STAGES(0)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_b), .pixel_in(pix_b),
    .hcount_out(h_b), .vcount_out(v_b), .hs_out(hs_b), .vs_out(vs_b), .ad_out(ad_b),
    .nf_out(nf_b), .fc_out(fc_b), .hs_d_out(hsd_b), .vs_d_out(vsd_b), .ad_d_out(add_b),
    .rgb_out(rgb_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Raster outputs after the k-th rising edge since reset release (k=0: in reset).
  function automatic raster_t model_at(cfg_t c, int k);
    raster_t r;
    int ht, vt, n, h, v, len, f0;
    ht  = c.ah + c.hfp + c.hsw + c.hbp;
    vt  = c.av + c.vfp + c.vsw + c.vbp;
    n   = (k > 1) ? k - 1 : 0;
    len = ht * vt;
    f0  = c.av * ht + c.ah;
    h   = n % ht;
    v   = (n / ht) % vt;
    r.h  = 11'(h);
    r.v  = 10'(v);
    r.ad = (h < c.ah) && (v < c.av);
    r.hs = !((h >= c.ah + c.hfp) && (h < c.ah + c.hfp + c.hsw));
    r.vs = !((v >= c.av + c.vfp) && (v < c.av + c.vfp + c.vsw));
    r.nf = ((n % len) == f0);
    r.fc = (n >= f0) ? 6'(((n - f0) / len + 1) % c.fps) : 6'd0;
    return r;
  endfunction

  // Pixel the pipeline returns now: pattern for the position seen pipe cycles ago, junk otherwise.
  function automatic logic [11:0] next_pixel(cfg_t c, int k);
    raster_t src;
    logic [31:0] rnd;
    rnd = $urandom;
    if (k - c.pipe >= 0) begin
      src = model_at(c, k - c.pipe);
      if (src.ad) return {src.h[3:0], src.v[3:0], 4'hA};
    end
    if (rnd[1:0] == 2'd0) return 12'hxxx;
    return rnd[11:0];
  endfunction

  task automatic check_inst(input string nm, input cfg_t c, input int k, input logic [11:0] prev_pix,
                            input raster_t got, input logic [2:0] got_d, input logic [11:0] got_rgb);
    raster_t er, eo;
    logic [2:0] ed;
    logic [11:0] erg;
    er = model_at(c, k);
    if (k - c.pipe - 1 >= 0) begin
      eo = model_at(c, k - c.pipe - 1);
      ed = {eo.hs, eo.vs, eo.ad};
    end else begin
      ed = 3'b110;
    end
    erg = ed[0] ? prev_pix : 12'h000;
    n_tests++;
    if (got !== er || got_d !== ed || got_rgb !== erg) begin
      n_fail++;
      $display("FAIL model_%s k=%0d: got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d hvad_d=%b rgb=%h, expected h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d hvad_d=%b rgb=%h",
               nm, k, got.h, got.v, got.hs, got.vs, got.ad, got.nf, got.fc, got_d, got_rgb,
               er.h, er.v, er.hs, er.vs, er.ad, er.nf, er.fc, ed, erg);
    end
  endtask

  task automatic expect_eq(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k_a = rst_a ? k_a + 1 : 0;
    k_b = rst_b ? k_b + 1 : 0;
    check_inst("A", cfg_a, k_a, prev_a, {h_a, v_a, hs_a, vs_a, ad_a, nf_a, fc_a}, {hsd_a, vsd_a, add_a}, rgb_a);
    check_inst("B", cfg_b, k_b, prev_b, {h_b, v_b, hs_b, vs_b, ad_b, nf_b, fc_b}, {hsd_b, vsd_b, add_b}, rgb_b);
    prev_a = next_pixel(cfg_a, k_a);
    prev_b = next_pixel(cfg_b, k_b);
    pix_a  = prev_a;
    pix_b  = prev_b;
  endtask

  initial begin
    raster_t exp_r;
    cfg_a = '{1024, 24, 136, 160, 768, 3, 6, 29, 60, 4};
    cfg_b = '{4, 1, 2, 1, 3, 1, 1, 1, 60, 0};
    //         rst adv    h     v  hs vs ad nf fc
    vecs[0]  = '{0, 5,    0,    0, 1, 1, 1, 0, 0};
    vecs[1]  = '{1, 1,    0,    0, 1, 1, 1, 0, 0};
    vecs[2]  = '{1, 1,    1,    0, 1, 1, 1, 0, 0};
    vecs[3]  = '{1, 1022, 1023, 0, 1, 1, 1, 0, 0};
    vecs[4]  = '{1, 1,    1024, 0, 1, 1, 0, 0, 0};
    vecs[5]  = '{1, 23,   1047, 0, 1, 1, 0, 0, 0};
    vecs[6]  = '{1, 1,    1048, 0, 0, 1, 0, 0, 0};
    vecs[7]  = '{1, 135,  1183, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{1, 1,    1184, 0, 1, 1, 0, 0, 0};
    vecs[9]  = '{1, 159,  1343, 0, 1, 1, 0, 0, 0};
    vecs[10] = '{1, 1,    0,    1, 1, 1, 1, 0, 0};

    rst_a = 1'b1;
    rst_b = 1'b1;
    pix_a = 12'h000;
    pix_b = 12'h000;
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    foreach (vecs[i]) begin
      rst_a = vecs[i].rst[0];
      repeat (vecs[i].adv) tick();
      exp_r.h  = 11'(vecs[i].h);
      exp_r.v  = 10'(vecs[i].v);
      exp_r.hs = vecs[i].hs[0];
      exp_r.vs = vecs[i].vs[0];
      exp_r.ad = vecs[i].ad[0];
      exp_r.nf = vecs[i].nf[0];
      exp_r.fc = 6'(vecs[i].fc);
      expect_eq($sformatf("vec%0d", i), 32'({h_a, v_a, hs_a, vs_a, ad_a, nf_a, fc_a}), 32'(exp_r));
    end

    // Mid-frame reset inside the horizontal sync of line 2.
    repeat (1344 + 1100) tick();
    expect_eq("pre_reset_pos", 32'({h_a, v_a}), 32'({11'd1100, 10'd2}));
    expect_eq("pre_reset_hs_d", 32'(hsd_a), 32'd0);
    rst_a = 1'b0;
    #1;
    expect_eq("async_reset_a", 32'({hsd_a, vsd_a, add_a, rgb_a, h_a, v_a, fc_a}),
              32'({1'b1, 1'b1, 1'b0, 12'h000, 11'd0, 10'd0, 6'd0}));
    repeat (3) tick();
    rst_a = 1'b1;
    repeat (2) tick();
    expect_eq("restart_a", 32'({h_a, v_a, fc_a}), 32'({11'd1, 10'd0, 6'd0}));
    repeat (2000) tick();

    // Small raster: frame counter up to the 60th new-frame pulse.
    rst_b = 1'b1;
    while (k_b < 2860) tick();
    expect_eq("fc_before_wrap", 32'({nf_b, fc_b}), 32'({1'b0, 6'd59}));
    tick();
    expect_eq("fc_wrap", 32'({nf_b, fc_b}), 32'({1'b1, 6'd0}));

    // Random-length reset at a random point of the small raster.
    repeat ($urandom_range(300, 50)) tick();
    rst_b = 1'b0;
    #1;
    expect_eq("async_reset_b", 32'({hsd_b, vsd_b, add_b, rgb_b, h_b, v_b, fc_b}),
              32'({1'b1, 1'b1, 1'b0, 12'h000, 11'd0, 10'd0, 6'd0}));
    repeat ($urandom_range(4, 1)) tick();
    rst_b = 1'b1;
    repeat (300) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
